// File: rtl/median_window_sched_if.sv
// Scheduler-side bus bundle: DRAM byte-read port plus the 3x3 window handoff to the median filter.
interface median_window_sched_if #(
    parameter int ADDR_W = 17
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              win_valid;
    logic              win_ready;
    logic [71:0]       win_data;
    logic [15:0]       win_x;
    logic [15:0]       win_y;

    modport master (
        output rd_req, rd_addr, win_valid, win_data, win_x, win_y,
        input  rd_gnt, rd_valid, rd_data, win_ready
    );

    modport slave (
        input  rd_req, rd_addr, win_valid, win_data, win_x, win_y,
        output rd_gnt, rd_valid, rd_data, win_ready
    );
endinterface

// File: rtl/median_window_sched.sv
// Raster-order 3x3 window fetcher for the median filter: 9 addressed byte reads per centre pixel.
// Define BORDER_ZERO_EN to zero-fill out-of-frame taps without reading them (default: edge replicate).
module median_window_sched #(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int ADDR_W    = 17,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    median_window_sched_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [3:0]        tap_q, tap_d;
    logic [71:0]       data_q, data_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              win_valid_q, win_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              skip_s, skip_next_s, last_pix_s;

    // Tap k covers dx = k%3-1, dy = k/3-1 around the centre pixel.
    function automatic int tap_cx(input logic [3:0] t, input logic [15:0] px);
        return int'(px) + (int'(t) % 3) - 1;
    endfunction

    function automatic int tap_cy(input logic [3:0] t, input logic [15:0] py);
        return int'(py) + (int'(t) / 3) - 1;
    endfunction

    function automatic logic tap_oob(input logic [3:0] t, input logic [15:0] px, input logic [15:0] py);
        int cx;
        int cy;
        cx = tap_cx(t, px);
        cy = tap_cy(t, py);
        return (cx < 0) || (cx >= IMG_W) || (cy < 0) || (cy >= IMG_H);
    endfunction

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [3:0] t, input logic [15:0] px, input logic [15:0] py);
        int cx;
        int cy;
        cx = tap_cx(t, px);
        cy = tap_cy(t, py);
        if (cx < 0)         cx = 0;
        if (cx > IMG_W - 1) cx = IMG_W - 1;
        if (cy < 0)         cy = 0;
        if (cy > IMG_H - 1) cy = IMG_H - 1;
        return ADDR_W'(BASE_ADDR + cy * IMG_W + cx);
    endfunction

    // Next-state, traversal counters and tap capture.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        tap_d      = tap_q;
        data_d     = data_q;
        last_pix_s = (x_q == 16'(IMG_W - 1)) && (y_q == 16'(IMG_H - 1));
`ifdef BORDER_ZERO_EN
        skip_s     = tap_oob(tap_q, x_q, y_q);
`else
        skip_s     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                    tap_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (skip_s) begin
                    data_d[{tap_q, 3'b000} +: 8] = 8'h00;
                    if (tap_q == 4'd8) begin
                        state_d = S_EMIT;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end else if (bus.rd_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.rd_valid) begin
                    data_d[{tap_q, 3'b000} +: 8] = bus.rd_data;
                    if (tap_q == 4'd8) begin
                        state_d = S_EMIT;
                    end else begin
                        tap_d   = tap_q + 4'd1;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EMIT: begin
                if (bus.win_ready) begin
                    tap_d = 4'd0;
                    if (last_pix_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        if (x_q == 16'(IMG_W - 1)) begin
                            x_d = 16'd0;
                            y_d = y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef BORDER_ZERO_EN
        skip_next_s = tap_oob(tap_d, x_d, y_d);
`else
        skip_next_s = 1'b0;
`endif
        // Outputs are decoded from the next state so they leave the flops aligned with it.
        rd_req_d    = (state_d == S_REQ) && !skip_next_s;
        if (state_d == S_REQ) begin
            rd_addr_d = tap_addr(tap_d, x_d, y_d);
        end else begin
            rd_addr_d = rd_addr_q;
        end
        win_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            tap_q       <= 4'd0;
            data_q      <= 72'd0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tap_q       <= tap_d;
            data_q      <= data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = data_q;
    assign bus.win_x     = x_q;
    assign bus.win_y     = y_q;
endmodule

// File: tb/tb_median_window_sched.sv
// Scoreboard bench for median_window_sched on a 4x3 frame at 0x100; pixel value = address[7:0].
module tb_median_window_sched;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 17;
    localparam int BASE = 'h100;
`ifdef BORDER_ZERO_EN
    localparam bit BZ = 1'b1;
`else
    localparam bit BZ = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [71:0] data;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    median_window_sched_if #(.ADDR_W(AW)) bus ();

    median_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [AW-1:0] exp_addr[$];
    win_t          exp_win[$];
    logic [AW-1:0] addr_log[$];
    bit   gnt_en = 1'b1;
    bit   rdy_en = 1'b1;
    bit   sb_on  = 1'b0;
    int   win_cnt = 0;
    int   done_cnt = 0;
    bit   pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;
    logic [71:0] w00, w11;

    // DRAM and filter model; decisions made at negedge take effect at the next posedge.
    task automatic responder();
        logic [AW-1:0] ea;
        win_t ew;
        forever begin
            @(negedge clk);
            bus.rd_valid = pend;
            bus.rd_data  = pend ? pend_data : 8'hEE;
            pend = 1'b0;
            bus.rd_gnt = bus.rd_req && gnt_en;
            if (bus.rd_gnt) begin
                pend = 1'b1;
                pend_data = bus.rd_addr[7:0];
                addr_log.push_back(bus.rd_addr);
                if (sb_on) begin
                    tests_run++;
                    if (exp_addr.size() == 0) begin
                        tests_failed++;
                        $display("FAIL rd_addr_extra: got %h, no read expected", bus.rd_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (bus.rd_addr !== ea) begin
                            tests_failed++;
                            $display("FAIL rd_addr: got %h expected %h", bus.rd_addr, ea);
                        end
                    end
                end
            end
            bus.win_ready = rdy_en;
            if (bus.win_valid && rdy_en) begin
                win_cnt++;
                if (bus.win_x == 16'd0 && bus.win_y == 16'd0) w00 = bus.win_data;
                if (bus.win_x == 16'd1 && bus.win_y == 16'd1) w11 = bus.win_data;
                if (sb_on) begin
                    tests_run++;
                    if (exp_win.size() == 0) begin
                        tests_failed++;
                        $display("FAIL win_extra: got (%0d,%0d), no window expected", bus.win_x, bus.win_y);
                    end else begin
                        ew = exp_win.pop_front();
                        if ({bus.win_x, bus.win_y, bus.win_data} !== ew) begin
                            tests_failed++;
                            $display("FAIL window: got (%0d,%0d) %h expected (%0d,%0d) %h",
                                     bus.win_x, bus.win_y, bus.win_data, ew.x, ew.y, ew.data);
                        end
                    end
                end
            end
            if (done) done_cnt++;
        end
    endtask

    task automatic push_frame();
        exp_addr.delete();
        exp_win.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                win_t w;
                w.x = 16'(x);
                w.y = 16'(y);
                w.data = '0;
                for (int t = 0; t < 9; t++) begin
                    int cx, cy, a;
                    bit oob;
                    cx = x + t % 3 - 1;
                    cy = y + t / 3 - 1;
                    oob = (cx < 0) || (cx >= W) || (cy < 0) || (cy >= H);
                    cx = (cx < 0) ? 0 : ((cx > W - 1) ? W - 1 : cx);
                    cy = (cy < 0) ? 0 : ((cy > H - 1) ? H - 1 : cy);
                    a = BASE + cy * W + cx;
                    if (oob && BZ) begin
                        w.data[8*t +: 8] = 8'h00;
                    end else begin
                        exp_addr.push_back(AW'(a));
                        w.data[8*t +: 8] = 8'(a);
                    end
                end
                exp_win.push_back(w);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({bus.rd_req, bus.win_valid, busy, done} !== 4'b0000 || bus.rd_addr !== '0 ||
            bus.win_data !== 72'd0 || bus.win_x !== 16'd0 || bus.win_y !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got req=%b wv=%b busy=%b done=%b addr=%h data=%h x=%0d y=%0d required all 0",
                     bus.rd_req, bus.win_valid, busy, done, bus.rd_addr, bus.win_data, bus.win_x, bus.win_y);
        end
        rst = 1'b0;
        sb_on = 1'b0;
        pulse_start();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.rd_req, bus.win_valid, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got req=%b wv=%b busy=%b done=%b required 0000",
                     bus.rd_req, bus.win_valid, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.rd_req, busy, bus.win_data} !== {2'b00, 72'd0}) begin
                tests_failed++;
                $display("FAIL late_rd_valid: got req=%b busy=%b data=%h required idle and cleared",
                         bus.rd_req, busy, bus.win_data);
            end
        end
    endtask

    task automatic test_raster();
        int a0, w0, d0;
        bit ok;
`ifdef BORDER_ZERO_EN
        int ref00[4] = '{'h100, 'h101, 'h104, 'h105};
        logic [71:0] ref_w00 = 72'h050400010000000000;
`else
        int ref00[9] = '{'h100, 'h100, 'h101, 'h100, 'h100, 'h101, 'h104, 'h104, 'h105};
        logic [71:0] ref_w00 = 72'h050404010000010000;
`endif
        push_frame();
        sb_on = 1'b1;
        w00 = '1;
        w11 = '1;
        a0 = addr_log.size();
        w0 = win_cnt;
        d0 = done_cnt;
        pulse_start();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end
`ifndef BORDER_ZERO_EN
        tests_run++;
        if (bus.rd_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_req_latency: got rd_req=%b required 1", bus.rd_req);
        end
`endif
        wait_done(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL raster_timeout: done not seen within bound");
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL after_done: got busy=%b done=%b required 00", busy, done);
        end
        @(posedge clk);
        #1;
        foreach (ref00[i]) begin
            tests_run++;
            if (addr_log[a0 + i] !== AW'(ref00[i])) begin
                tests_failed++;
                $display("FAIL addr00[%0d]: got %h required %h", i, addr_log[a0 + i], ref00[i]);
            end
        end
        tests_run++;
        if (w00 !== ref_w00 || w11 !== 72'h0A0908060504020100) begin
            tests_failed++;
            $display("FAIL win_data_ref: got w00=%h w11=%h required %h %h", w00, w11, ref_w00, 72'h0A0908060504020100);
        end
        tests_run++;
        if (win_cnt - w0 !== 12 || done_cnt - d0 !== 1 || exp_addr.size() !== 0 || exp_win.size() !== 0) begin
            tests_failed++;
            $display("FAIL raster_counts: got windows=%0d done=%0d left_addr=%0d left_win=%0d required 12 1 0 0",
                     win_cnt - w0, done_cnt - d0, exp_addr.size(), exp_win.size());
        end
    endtask

    task automatic test_win_stall();
        int w0;
        bit ok, seen;
        logic [71:0] hd;
        logic [15:0] hx, hy;
        push_frame();
        w0 = win_cnt;
        rdy_en = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = bus.win_valid;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL stall_emit_timeout: win_valid not seen");
        end
        hd = bus.win_data;
        hx = bus.win_x;
        hy = bus.win_y;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.win_valid, bus.rd_req, bus.win_data, bus.win_x, bus.win_y} !== {2'b10, hd, hx, hy}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got wv=%b req=%b %h (%0d,%0d) required 1 0 %h (%0d,%0d)",
                         i, bus.win_valid, bus.rd_req, bus.win_data, bus.win_x, bus.win_y, hd, hx, hy);
            end
        end
        @(posedge clk);
        #1 rdy_en = 1'b1;
        wait_done(ok);
        @(posedge clk);
        #1;
        tests_run++;
        if (!ok || win_cnt - w0 !== 12 || exp_win.size() !== 0) begin
            tests_failed++;
            $display("FAIL stall_release: got done=%b windows=%0d left=%0d required 1 12 0", ok, win_cnt - w0, exp_win.size());
        end
    endtask

    task automatic test_back_to_back();
        int w0, d0;
        bit ok, seen;
        logic [AW-1:0] ha;
        push_frame();
        w0 = win_cnt;
        d0 = done_cnt;
        gnt_en = 1'b0;
        pulse_start();
        seen = bus.rd_req;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rd_req;
        end
        ha = bus.rd_addr;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = (i == 3);
            tests_run++;
            if (bus.rd_req !== 1'b1 || bus.rd_addr !== ha) begin
                tests_failed++;
                $display("FAIL gnt_stall[%0d]: got req=%b addr=%h required 1 %h", i, bus.rd_req, bus.rd_addr, ha);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1 gnt_en = 1'b1;
        wait_done(ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || bus.rd_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_in_done: got busy=%b req=%b required 0 0", busy, bus.rd_req);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (!ok || win_cnt - w0 !== 12 || done_cnt - d0 !== 1 || exp_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL b2b_counts: got done=%b windows=%0d dones=%0d left=%0d required 1 12 1 0",
                     ok, win_cnt - w0, done_cnt - d0, exp_addr.size());
        end
    endtask

    initial begin
        bus.rd_gnt    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = 8'h00;
        bus.win_ready = 1'b0;
        w00 = '1;
        w11 = '1;
        fork
            responder();
        join_none
        test_reset();
        test_raster();
        test_win_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
